// File: rtl/expire_timestamp_fifo_if.sv
// Avalon-MM slave bus of the expire timestamp FIFO.
// A read or write takes effect on the clock edge that samples it with chipselect=1;
// read data appears on readdata one cycle later and holds until the next read.
interface expire_timestamp_fifo_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/expire_timestamp_fifo.sv
// Captures a free-running timestamp on each rising edge of counter_expire into a FIFO
// that the CPU drains over Avalon-MM; raises an interrupt on level threshold or overflow.
module expire_timestamp_fifo #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          counter_expire,
    expire_timestamp_fifo_if.slave        bus,
    output logic                          fifo_irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [TS_WIDTH-1:0] timestamp;
    logic                expire_q;
    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic                overflow;
    logic                enable;
    logic [6:0]          threshold;
    logic [31:0]         readdata_q;
    logic [31:0]         rd_mux;

    logic       rd_sel, wr_sel;
    logic       edge_hit, push_req, push_ok, drop;
    logic       pop, flush, ovf_clr, full;
    logic [PW-1:0] push_addr;
    logic [6:0] thr_eff;
    logic [7:0] level_ext;
    logic       unused_bits;

    assign rd_sel    = bus.chipselect & bus.read;
    assign wr_sel    = bus.chipselect & bus.write;
    assign edge_hit  = counter_expire & ~expire_q;
    assign push_req  = edge_hit & enable;
    assign full      = (level == LW'(DEPTH));
    assign pop       = rd_sel & (bus.address == 2'd0) & (level != '0);
    assign flush     = wr_sel & (bus.address == 2'd2) & bus.writedata[1];
    assign ovf_clr   = wr_sel & (bus.address == 2'd2) & bus.writedata[0];
    // A flush empties the FIFO first, so a coinciding push always lands in slot 0.
    assign push_ok   = push_req & (flush | ~full | pop);
    assign drop      = push_req & full & ~pop & ~flush;
    assign push_addr = flush ? '0 : wr_ptr;
    assign thr_eff   = (threshold == 7'd0) ? 7'd1 : threshold;
    assign level_ext = 8'(level);
    assign unused_bits = &{1'b0, bus.writedata[31:8]};

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux = (level != '0) ? 32'(mem[rd_ptr]) : 32'd0;
            2'd1:    rd_mux = {24'd0, 7'(level), overflow};
            2'd2:    rd_mux = {31'd0, fifo_irq};
            default: rd_mux = {24'd0, threshold, enable};
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[push_addr] <= timestamp;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timestamp  <= '0;
            expire_q   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            enable     <= 1'b0;
            threshold  <= 7'd1;
            fifo_irq   <= 1'b0;
            readdata_q <= '0;
        end else begin
            timestamp <= timestamp + 1'b1;
            expire_q  <= counter_expire;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= push_ok ? PW'(1) : '0;
                level  <= push_ok ? LW'(1) : '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop)      level <= level + 1'b1;
                else if (!push_ok && pop) level <= level - 1'b1;
            end

            // A new drop outranks a same-cycle clear so no overflow event is lost.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            if (wr_sel && bus.address == 2'd3) begin
                enable    <= bus.writedata[0];
                threshold <= bus.writedata[7:1];
            end

            fifo_irq <= enable & ((level_ext >= {1'b0, thr_eff}) | overflow);

            if (rd_sel) readdata_q <= rd_mux;
        end
    end

    assign bus.readdata = readdata_q;

endmodule
